luma_out_packer: RTL and testbench



---
 rtl/luma_pkg.sv | 20 ++
 rtl/luma_out_packer_fifo.sv | 60 ++++++
 rtl/luma_out_packer.sv | 148 ++++++++++++++
 tb/tb_luma_out_packer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/luma_pkg.sv
// Shared types and helpers for the luma output path: pixel widths, pack FSM
// states and the 8-bit pixel clipper.
package luma_pkg;

   localparam int PIX_W      = 8;
   localparam int PE_OUT_W   = 17;
   localparam int WORD_BYTES = 4;

   typedef enum logic {EMPTY, FILL} pack_state_t;

   function automatic logic [PIX_W-1:0] clip_pix(input logic signed [PE_OUT_W:0] r);
      if (r < 0)
         return '0;
      else if (r > 18'sd255)
         return '1;
      else
         return r[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/luma_out_packer_fifo.sv
// Shift-register word FIFO: entry 0 is always the head, so the read side comes
// straight from flops; a full FIFO still accepts a write when it pops that cycle.
module sync_fifo_word #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem      [DEPTH];
   logic [WIDTH-1:0] mem_next [DEPTH];
   logic [LW-1:0]    level_next;
   logic [LW-1:0]    wr_idx;
   logic             valid_q;
   logic             pop;
   logic             push;

   assign pop  = rd_en && valid_q;
   assign push = wr_en && ((level != LW'(DEPTH)) || pop);

   always_comb begin
      mem_next   = mem;
      wr_idx     = pop ? (level - LW'(1)) : level;
      level_next = level + LW'(push) - LW'(pop);
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++)
            mem_next[i] = mem[i+1];
         mem_next[DEPTH-1] = '0;
      end
      for (int i = 0; i < DEPTH; i++)
         if (push && (wr_idx == LW'(i)))
            mem_next[i] = wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         level   <= '0;
         valid_q <= 1'b0;
      end else begin
         mem     <= mem_next;
         level   <= level_next;
         valid_q <= (level_next != '0);
      end
   end

   assign rd_valid = valid_q;
   assign rd_data  = mem[0];

endmodule

// File: rtl/luma_out_packer.sv
// Rounds, shifts and clips PE samples to 8-bit pixels, packs four per 32-bit
// word (shorter on block end) and queues the words for the frame-memory writer.
module luma_out_packer
   import luma_pkg::*;
#(
   parameter int SHIFT      = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          Vin,
   input  logic [16:0]                   InData,
   input  logic                          last_in,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [31:0]                   out_data,
   output logic [3:0]                    out_be,
   output logic                          out_last,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW     = $clog2(FIFO_DEPTH) + 1;
   localparam int WORD_W = PIX_W * WORD_BYTES + WORD_BYTES + 1;
   localparam logic signed [PE_OUT_W:0] RND = 18'sd1 <<< (SHIFT - 1);

   logic signed [PE_OUT_W:0] sum;
   logic signed [PE_OUT_W:0] shifted;
   logic                     s1_valid;
   logic [PIX_W-1:0]         s1_pix;
   logic                     s1_last;

   pack_state_t   state, state_next;
   logic [1:0]    lane, lane_next;
   logic [23:0]   hold, hold_next;
   logic [31:0]   hold_ext;
   logic          emit;
   logic [31:0]   word_data;
   logic [3:0]    word_be;
   logic          word_last;
   logic          pop;
   logic          drop;
   logic [WORD_W-1:0] head;

   // One sign bit of headroom makes the rounding add overflow-free.
   assign sum     = $signed({InData[16], InData}) + RND;
   assign shifted = sum >>> SHIFT;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_pix   <= '0;
         s1_last  <= 1'b0;
      end else begin
         s1_valid <= Vin;
         if (Vin) begin
            s1_pix  <= clip_pix(shifted);
            s1_last <= last_in;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= EMPTY;
         lane  <= '0;
         hold  <= '0;
      end else begin
         state <= state_next;
         lane  <= lane_next;
         hold  <= hold_next;
      end
   end

   // Lane is 0 in EMPTY, so one word-assembly path serves both states.
   always_comb begin
      state_next = state;
      lane_next  = lane;
      hold_next  = hold;
      hold_ext   = {8'h00, hold};
      emit       = 1'b0;
      word_data  = '0;
      word_be    = '0;
      word_last  = 1'b0;
      if (s1_valid) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (i < int'(lane))
               word_data[i*8 +: 8] = hold_ext[i*8 +: 8];
            else if (i == int'(lane))
               word_data[i*8 +: 8] = s1_pix;
            if (i <= int'(lane))
               word_be[i] = 1'b1;
         end
         word_last = s1_last;
         hold_ext[int'(lane)*8 +: 8] = s1_pix;
         hold_next = hold_ext[23:0];
         unique case (state)
            EMPTY: begin
               if (s1_last) begin
                  emit = 1'b1;
               end else begin
                  state_next = FILL;
                  lane_next  = 2'd1;
               end
            end
            FILL: begin
               if ((lane == 2'd3) || s1_last) begin
                  emit       = 1'b1;
                  state_next = EMPTY;
                  lane_next  = 2'd0;
               end else begin
                  lane_next = lane + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pop  = out_valid && out_ready;
   assign drop = emit && (fifo_level == LW'(FIFO_DEPTH)) && !pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end

   sync_fifo_word #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (emit),
      .wr_data  ({word_data, word_be, word_last}),
      .rd_en    (out_ready),
      .rd_valid (out_valid),
      .rd_data  (head),
      .level    (fifo_level)
   );

   assign out_data = head[WORD_W-1:5];
   assign out_be   = head[4:1];
   assign out_last = head[0];

endmodule

// File: tb/tb_luma_out_packer.sv
// Randomised and directed checks of luma_out_packer against a queue-based
// model of the round/clip and packing rules.
module tb_luma_out_packer;

   localparam int SHIFT = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        Vin;
   logic [16:0] InData;
   logic        last_in;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [3:0]  out_be;
   logic        out_last;
   logic        overflow;
   logic [2:0]  fifo_level;

   int total = 0;
   int bad   = 0;

   logic [36:0] got   [$];
   logic [36:0] exp_q [$];
   logic [7:0]  pend  [$];

   luma_out_packer #(.SHIFT(SHIFT), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .Vin        (Vin),
      .InData     (InData),
      .last_in    (last_in),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_be     (out_be),
      .out_last   (out_last),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // Words leaving the port, captured mid-cycle before the popping edge.
   always @(negedge clk)
      if (!reset && out_valid && out_ready)
         got.push_back({out_data, out_be, out_last});

   function automatic logic [7:0] ref_pix(input logic [16:0] d);
      int v;
      int r;
      int q;
      v = $signed(d);
      r = v + (2 ** (SHIFT - 1));
      if (r >= 0) q = r / (2 ** SHIFT);
      else        q = -((-r + (2 ** SHIFT) - 1) / (2 ** SHIFT));
      if (q < 0)   q = 0;
      if (q > 255) q = 255;
      return 8'(q);
   endfunction

   task automatic model_sample(input logic [16:0] d, input logic l);
      logic [31:0] data;
      logic [3:0]  be;
      pend.push_back(ref_pix(d));
      if (pend.size() == 4 || l) begin
         data = '0;
         be   = '0;
         for (int i = 0; i < pend.size(); i++) begin
            data[i*8 +: 8] = pend[i];
            be[i] = 1'b1;
         end
         exp_q.push_back({data, be, l});
         pend.delete();
      end
   endtask

   task automatic applyStimulus(input logic [16:0] d, input logic l);
      Vin     = 1'b1;
      InData  = d;
      last_in = l;
      model_sample(d, l);
      @(posedge clk); #1;
      Vin     = 1'b0;
      last_in = 1'b0;
   endtask

   task automatic apply_reset();
      Vin     = 1'b0;
      last_in = 1'b0;
      reset   = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      got.delete();
      exp_q.delete();
      pend.delete();
   endtask

   task automatic wait_words(input int n, input int budget);
      int c = 0;
      while (got.size() < n && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Vin = 1'b0; InData = '0; last_in = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_be, out_last, overflow, fifo_level} !== '0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got valid=%b data=%h be=%b last=%b ovf=%b lvl=%0d want all 0",
                  out_valid, out_data, out_be, out_last, overflow, fifo_level);
      end
      #1 reset = 1'b0;
   endtask

   task automatic test_round_clip();
      logic [16:0] din  [5];
      logic [7:0]  want [5];
      din  = '{17'd6400, 17'h1FE0C, 17'd20000, 17'd31, 17'd32};
      want = '{8'd100, 8'd0, 8'd255, 8'd0, 8'd1};
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(din[i], 1'b1);
      wait_words(5, 20);
      total++;
      if (got.size() != 5) begin
         bad++;
         $display("[TB] FAIL round_count got %0d want 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         total++;
         if (got[i] !== {24'h0, want[i], 4'b0001, 1'b1}) begin
            bad++;
            $display("[TB] FAIL round_clip[%0d] got %h want %h", i, got[i], {24'h0, want[i], 4'b0001, 1'b1});
         end
      end
   endtask

   task automatic test_packing();
      apply_reset();
      out_ready = 1'b1;
      applyStimulus(17'd1024, 1'b0);
      applyStimulus(17'd2048, 1'b0);
      applyStimulus(17'd3072, 1'b0);
      applyStimulus(17'd4096, 1'b0);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL pack_latency_early got valid=%b want 0", out_valid);
      end
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_be, out_last} !== {1'b1, 32'h40302010, 4'b1111, 1'b0}) begin
         bad++;
         $display("[TB] FAIL pack_word got v=%b %h be=%b l=%b want v=1 40302010 be=1111 l=0",
                  out_valid, out_data, out_be, out_last);
      end
   endtask

   task automatic test_short_block();
      apply_reset();
      out_ready = 1'b1;
      applyStimulus(17'd1024, 1'b0);
      applyStimulus(17'd2048, 1'b1);
      applyStimulus(17'd5440, 1'b1);
      wait_words(2, 20);
      total++;
      if (got.size() != 2) begin
         bad++;
         $display("[TB] FAIL short_count got %0d want 2", got.size());
      end else begin
         total++;
         if (got[0] !== {32'h00002010, 4'b0011, 1'b1}) begin
            bad++;
            $display("[TB] FAIL short_word got %h want %h", got[0], {32'h00002010, 4'b0011, 1'b1});
         end
         total++;
         if (got[1] !== {32'h00000055, 4'b0001, 1'b1}) begin
            bad++;
            $display("[TB] FAIL short_next_byte0 got %h want %h", got[1], {32'h00000055, 4'b0001, 1'b1});
         end
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) applyStimulus(17'($urandom), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ovf_full got lvl=%0d ovf=%b want lvl=4 ovf=1", fifo_level, overflow);
      end
      total++;
      if ({out_valid, out_data, out_be, out_last} !== {1'b1, exp_q[0]}) begin
         bad++;
         $display("[TB] FAIL ovf_head got %h want %h", {out_valid, out_data, out_be, out_last}, {1'b1, exp_q[0]});
      end
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (got.size() != 4) begin
         bad++;
         $display("[TB] FAIL ovf_drain_count got %0d want 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL ovf_drain[%0d] got %h want %h", i, got[i], exp_q[i]);
         end
      end
      total++;
      if (fifo_level !== 3'd0 || overflow !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ovf_sticky got lvl=%0d ovf=%b want lvl=0 ovf=1", fifo_level, overflow);
      end
   endtask

   task automatic test_full_pop();
      apply_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 19; i++) applyStimulus(17'($urandom), 1'b0);
      applyStimulus(17'($urandom), 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL fullpop_state got lvl=%0d ovf=%b want lvl=4 ovf=0", fifo_level, overflow);
      end
      total++;
      if (got.size() != 1 || {out_data, out_be, out_last} !== exp_q[1]) begin
         bad++;
         $display("[TB] FAIL fullpop_head got n=%0d head=%h want n=1 head=%h",
                  got.size(), {out_data, out_be, out_last}, exp_q[1]);
      end
      out_ready = 1'b1;
      wait_words(5, 20);
      total++;
      if (got.size() != 5) begin
         bad++;
         $display("[TB] FAIL fullpop_count got %0d want 5", got.size());
      end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL fullpop_word[%0d] got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_word();
      apply_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus(17'($urandom_range(64, 16000)), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_be, out_last, overflow, fifo_level} !== '0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs got v=%b %h be=%b l=%b ovf=%b lvl=%0d want all 0",
                  out_valid, out_data, out_be, out_last, overflow, fifo_level);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      got.delete();
      exp_q.delete();
      pend.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(17'($urandom_range(64, 16000)), 1'b0);
      wait_words(1, 20);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (got.size() != 1 || got[0] !== exp_q[0]) begin
         bad++;
         $display("[TB] FAIL midreset_word got n=%0d w=%h want n=1 w=%h",
                  got.size(), (got.size() > 0) ? got[0] : 37'h0, exp_q[0]);
      end
   endtask

   task automatic test_random();
      int n;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 1) == 0)
               applyStimulus(17'($urandom_range(0, 16383)), ($urandom_range(0, 5) == 0));
            else
               applyStimulus(17'($urandom), ($urandom_range(0, 5) == 0));
         end else begin
            @(posedge clk); #1;
         end
      end
      applyStimulus(17'($urandom), 1'b1);
      n = exp_q.size();
      wait_words(n, 50);
      total++;
      if (got.size() != n || overflow !== 1'b0) begin
         bad++;
         $display("[TB] FAIL random_count got %0d ovf=%b want %0d ovf=0", got.size(), overflow, n);
      end
      for (int i = 0; i < n && i < got.size(); i++) begin
         total++;
         if (got[i] !== exp_q[i]) begin
            bad++;
            $display("[TB] FAIL random_word[%0d] got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_clip();
      test_packing();
      test_short_block();
      test_overflow();
      test_full_pop();
      test_reset_mid_word();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
